cdc_rx_alu: RTL and testbench
=============================

// Module: cdc_rx_alu
// PURPOSE
//  Single-clock receive side of a toggle-handshake CDC link with a queued arithmetic engine.
//  A foreign-domain sender flips req_tog after setting stable operands. This block:
//  - synchronises req_tog and captures the operands into a FIFO;
//  - returns ack_tog so the sender may change its operands;
//  - computes one of four operations and presents results on a valid/ready output.
//  Successor to the fixed 4-bit add/mul CDC unit: parametrised width and depth, four modes,
//  lossless backpressure.
// PARAMETERS
//  WIDTH  4          operand width in bits (>=2)
//  DEPTH  4          request FIFO entries (power of two, >=2)
//  OUT_W  2*WIDTH    result width; fixed at 2*WIDTH (mul must not overflow)
// PORTS
//  clk        in   1       sole clock; every flop is on posedge clk
//  rst_n      in   1       asynchronous, active-low reset
//  req_tog    in   1       request toggle from foreign domain (asynchronous)
//  in_a       in   WIDTH   operand A; sender holds it stable from req_tog flip until ack_tog flips
//  in_b       in   WIDTH   operand B; same stability rule
//  mode       in   2       00 ADD, 01 MUL, 10 SUB, 11 ABSDIFF; same stability rule
//  ack_tog    out  1       flips once per captured request
//  out_ready  in   1       downstream accepts out when high with out_valid
//  out_valid  out  1       result valid; held until accepted
//  out        out  OUT_W   result
//  fifo_full  out  1       FIFO holds DEPTH entries
// BEHAVIOUR
//  Reset: ack_tog=0, out_valid=0, out=0, fifo_full=0, FIFO empty, req_q=0, FSM=IDLE.
//   Reset mid-operation discards all queued and in-flight work.
//  Ingress:
//   - req_tog passes through the existing 2-flop synchronizer to give req_s.
//   - Event: evt = req_s ^ req_q.
//   - If evt && !fifo_full (full sampled before any same-cycle pop): push {mode,in_a,in_b},
//     set req_q<=req_s, and flip ack_tog.
//   - If evt && fifo_full: no push, req_q unchanged, ack_tog unchanged. evt stays pending
//     and is accepted on the first cycle with full=0. Never drop, never double-capture.
//   - Latency from req_tog flip to ack_tog flip: 3 clk when not full.
//  Egress FSM:
//   - IDLE: if FIFO non-empty, pop the head -> COMPUTE.
//   - COMPUTE: register out=f(entry), out_valid<=1 -> OUT.
//   - OUT: hold out and out_valid until out_ready. In the accept cycle: out_valid<=0, out<=0
//     -> IDLE.
//   - Max throughput: 1 result per 3 clk.
//   - Capacity before ack stalls: DEPTH queued + 1 in flight.
//  Arithmetic: operands zero-extended to OUT_W.
//   - ADD: a+b.
//   - MUL: a*b.
//   - SUB: (a-b) mod 2^OUT_W.
//   - ABSDIFF: |a-b|.
//  Ordering: results leave in strict request order.
//  Pointers: wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
//   A simultaneous push and pop when not full leaves count unchanged.
// CONFIGURATION
//  CDC_RX_STATS_EN defined:
//   - adds output stall_cnt[7:0], saturating at 8'hFF, cleared only by reset;
//   - stall_cnt increments every cycle evt && fifo_full.
//  CDC_RX_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package cdc_rx_pkg:
//   - mode_e enum {ADD,MUL,SUB,ABSDIFF};
//   - state_e enum {IDLE,COMPUTE,OUT};
//   - packed struct req_t {mode_e mode; a; b} sized by WIDTH via parameterised typedef
//     in the module.
//  Sub-module cdc_rx_fifo: synchronous FIFO with WIDTH and DEPTH parameters.
//   - push/pop/full/empty interface;
//   - async active-low reset;
//   - no read-during-empty or write-during-full side effects.
//  Reuse the existing synchronizer for req_tog; no other synchronisation inside.
// TESTING
//  1. Assert rst_n=0 mid-sim -> out_valid=0, out=0, ack_tog=0, fifo_full=0 immediately
//     (asynchronous).
//  2. a=9, b=7, ADD, flip req_tog, out_ready=1 -> ack_tog flips 3 clk later; out=8'd16 with
//     out_valid for 1 clk.
//  3. a=15, b=15, MUL -> out=8'd225. Then a=3, b=5, SUB -> 8'hFE. Then ABSDIFF -> 8'd2.
//  4. out_ready=0; send 7 requests with DEPTH=4 ->
//     - exactly 5 ack flips; fifo_full=1; 6th request pending;
//     - raise out_ready -> remaining acks arrive; all 7 results in order.
//  5. Pulse rst_n during OUT with 3 queued -> no further out_valid; next request yields its
//     own correct result.
//  6. CDC_RX_STATS_EN defined, test 4 stall of N cycles -> stall_cnt==N.
//     Force >255 stall cycles -> stall_cnt==8'hFF.

Source files
------------

// File: rtl/cdc_rx_pkg.sv
// Shared types for the CDC receive ALU: operation modes, egress FSM states.
package cdc_rx_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    MUL     = 2'b01,
    SUB     = 2'b10,
    ABSDIFF = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUT
  } state_e;

  localparam int unsigned STALL_W = 8;

endpackage

// File: rtl/cdc_rx_fifo.sv
// Synchronous request FIFO; push when full and pop when empty are ignored.
module cdc_rx_fifo
  import cdc_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdc_rx_alu.sv
// Toggle-handshake CDC receiver feeding a queued ADD/MUL/SUB/ABSDIFF engine.
// Optional stall statistics output enabled by defining CDC_RX_STATS_EN.
module cdc_rx_alu
  import cdc_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OUT_W = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_tog,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         mode,
  output logic               ack_tog,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out,
  output logic               fifo_full
`ifdef CDC_RX_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    mode_e            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  localparam int unsigned REQ_W = $bits(req_t);

  logic       req_s1;
  logic       req_s;
  logic       req_q;
  logic       evt;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  req_t       wr_req;
  logic [REQ_W-1:0] head;
  req_t       entry;
  state_e     state;
  state_e     state_d;

  // Two-flop synchronizer: the only signal crossing into this domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_s1 <= 1'b0;
      req_s  <= 1'b0;
    end else begin
      req_s1 <= req_tog;
      req_s  <= req_s1;
    end
  end

  assign evt    = req_s ^ req_q;
  assign push   = evt && !fifo_full;
  assign wr_req = '{mode: mode_e'(mode), a: in_a, b: in_b};

  // A blocked event stays pending because req_q only advances on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      ack_tog <= 1'b0;
    end else if (push) begin
      req_q   <= req_s;
      ack_tog <= ~ack_tog;
    end
  end

  cdc_rx_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_data(wr_req),
    .pop    (pop),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  function automatic logic [OUT_W-1:0] calc(input req_t r);
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;
    a    = OUT_W'(r.a);
    b    = OUT_W'(r.b);
    calc = '0;
    case (r.mode)
      ADD:     calc = a + b;
      MUL:     calc = a * b;
      SUB:     calc = a - b;
      ABSDIFF: calc = (a >= b) ? a - b : b - a;
      default: calc = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop) entry <= req_t'(head);
      if (state == COMPUTE) begin
        out       <= calc(entry);
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out       <= '0;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CDC_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt <= '0;
    else if (evt && fifo_full && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cdc_rx_alu.sv
// Directed self-checking bench for cdc_rx_alu (WIDTH=4, DEPTH=4).
module tb_cdc_rx_alu;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_tog;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       mode;
  logic             ack_tog;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out;
  logic             fifo_full;
`ifdef CDC_RX_STATS_EN
  logic [7:0]       stall_cnt;
`endif

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  int unsigned n_results = 0;
  int unsigned valid_cycles = 0;
  logic        ack_seen = 1'b0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  cdc_rx_alu #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_tog  (req_tog),
    .in_a     (in_a),
    .in_b     (in_b),
    .mode     (mode),
    .ack_tog  (ack_tog),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out      (out),
    .fifo_full(fifo_full)
`ifdef CDC_RX_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      valid_cycles++;
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 1'b0);
        else                   check_eq("result", out, exp_q.pop_front());
        n_results++;
      end
    end
  end

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_tog   = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    mode      = 2'b00;
    ack_seen  = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_results    = 0;
    valid_cycles = 0;
  endtask

  task automatic start_req(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m,
                           input logic [7:0] exp);
    @(posedge clk);
    #1;
    in_a    = a;
    in_b    = b;
    mode    = m;
    req_tog = ~req_tog;
    exp_q.push_back(exp);
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      @(posedge clk);
      lat++;
      #1;
      if (ack_tog !== ack_seen) begin
        ack_seen = ack_tog;
        return;
      end
    end
    lat = budget;
  endtask

  task automatic send(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] m, input logic [7:0] exp);
    int lat;
    start_req(a, b, m, exp);
    wait_ack(20, lat);
    check_eq(tag, lat, 3);
  endtask

  task automatic wait_results(input string tag, input int unsigned target);
    for (int i = 0; i < 60; i++) begin
      if (n_results >= target) break;
      @(posedge clk);
      #2;
    end
    check_eq(tag, n_results, target);
  endtask

  logic [3:0] v_a   [7] = '{4'd1, 4'd4, 4'd2, 4'd12, 4'd0, 4'd15, 4'd0};
  logic [3:0] v_b   [7] = '{4'd2, 4'd3, 4'd9, 4'd5, 4'd15, 4'd1, 4'd1};
  logic [1:0] v_m   [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
  logic [7:0] v_exp [7] = '{8'd3, 8'd12, 8'hF9, 8'd7, 8'd15, 8'd16, 8'hFF};

  initial begin
    int lat;

    // Reset state
    rst_n = 1'b0;
    req_tog = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; mode = '0;
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out", out, 8'h00);
    check_eq("rst_ack", ack_tog, 1'b0);
    check_eq("rst_full", fifo_full, 1'b0);
    reset_dut();

    // Single ADD with downstream ready
    @(posedge clk); #1 out_ready = 1'b1;
    send("add_latency", 4'd9, 4'd7, 2'd0, 8'd16);
    wait_results("add_result_cnt", 1);
    repeat (3) @(posedge clk);
    check_eq("add_valid_cycles", valid_cycles, 1);

    // MUL, SUB wraparound, ABSDIFF
    send("mul_latency", 4'd15, 4'd15, 2'd1, 8'd225);
    wait_results("mul_result_cnt", 2);
    send("sub_latency", 4'd3, 4'd5, 2'd2, 8'hFE);
    wait_results("sub_result_cnt", 3);
    send("absdiff_latency", 4'd3, 4'd5, 2'd3, 8'd2);
    wait_results("absdiff_result_cnt", 4);

    // Backpressure: DEPTH queued + 1 in flight, sixth request held pending
    reset_dut();
    for (int i = 0; i < 5; i++) send("bp_latency", v_a[i], v_b[i], v_m[i], v_exp[i]);
    check_eq("bp_ack_parity", ack_tog, 1'b1);
    check_eq("bp_full", fifo_full, 1'b1);
    start_req(v_a[5], v_b[5], v_m[5], v_exp[5]);
    wait_ack(20, lat);
    check_eq("bp_pending_no_ack", lat, 20);
    check_eq("bp_ack_held", ack_tog, 1'b1);
    check_eq("bp_no_output_yet", n_results, 0);
`ifdef CDC_RX_STATS_EN
    check_eq("stall_cnt_18", stall_cnt, 8'd18);
`endif
    out_ready = 1'b1;
    wait_ack(20, lat);
    check_eq("bp_sixth_acked", lat < 20, 1'b1);
    start_req(v_a[6], v_b[6], v_m[6], v_exp[6]);
    wait_ack(20, lat);
    check_eq("bp_seventh_acked", lat < 20, 1'b1);
    wait_results("bp_result_cnt", 7);
    check_eq("bp_queue_drained", exp_q.size(), 0);
    check_eq("bp_final_ack", ack_tog, 1'b1);

    // Reset while a result is held with three more queued
    reset_dut();
    send("r5_latency0", 4'd1, 4'd1, 2'd0, 8'd2);
    send("r5_latency1", 4'd2, 4'd2, 2'd0, 8'd4);
    send("r5_latency2", 4'd3, 4'd3, 2'd0, 8'd6);
    send("r5_latency3", 4'd4, 4'd4, 2'd0, 8'd8);
    check_eq("r5_holding_valid", out_valid, 1'b1);
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    req_tog = 1'b0;
    exp_q.delete();
    #1;
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_out", out, 8'h00);
    check_eq("async_rst_ack", ack_tog, 1'b0);
    check_eq("async_rst_full", fifo_full, 1'b0);
    ack_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    valid_cycles = 0;
    n_results    = 0;
    out_ready    = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("r5_no_stale_valid", valid_cycles, 0);
    send("r5_new_latency", 4'd6, 4'd2, 2'd2, 8'd4);
    wait_results("r5_new_result_cnt", 1);

`ifdef CDC_RX_STATS_EN
    // Saturating stall counter
    reset_dut();
    for (int i = 0; i < 5; i++) send("sat_latency", v_a[i], v_b[i], v_m[i], v_exp[i]);
    start_req(v_a[5], v_b[5], v_m[5], v_exp[5]);
    repeat (300) @(posedge clk);
    #1;
    check_eq("stall_cnt_sat", stall_cnt, 8'hFF);
    out_ready = 1'b1;
    wait_ack(20, lat);
    wait_results("sat_result_cnt", 6);
    check_eq("stall_cnt_hold", stall_cnt, 8'hFF);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
